// File: rtl/memory_interface_v4.sv
// memory_interface_v4: turns one 32-bit CPU load/store of any size and alignment
// into single-port SRAM beats, using read-modify-write for partially covered stores.
// Ports:
//   clk, reset (async, active-low)
//   CPU side: address, data_in, load, store, is_signed, word_type,
//             data_out, output_valid, write_ready, busy
//   SRAM side: from_mem_data, to_mem_mem_enable, to_mem_read_enable,
//              to_mem_write_enable, to_mem_address, to_mem_data
module memory_interface_v4 #(
    parameter  int ADDR_W    = 13,
    parameter  int MEM_BYTES = 2,
    parameter  int READ_LAT  = 1,
    localparam int MEM_DW    = 8 * MEM_BYTES,
    localparam int OFF_W     = $clog2(MEM_BYTES),
    localparam int MEM_AW    = ADDR_W - OFF_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       data_in,
    input  logic              load,
    input  logic              store,
    input  logic              is_signed,
    input  logic [1:0]        word_type,
    input  logic [MEM_DW-1:0] from_mem_data,
    output logic              to_mem_mem_enable,
    output logic              to_mem_read_enable,
    output logic              to_mem_write_enable,
    output logic [MEM_AW-1:0] to_mem_address,
    output logic [MEM_DW-1:0] to_mem_data,
    output logic [31:0]       data_out,
    output logic              output_valid,
    output logic              write_ready,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_WR,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [1:0]          r_off;
    logic [2:0]          r_size;
    logic [2:0]          r_nbeats;
    logic [2:0]          r_beat;
    logic [1:0]          r_wait;
    logic [MEM_AW-1:0]   r_base;
    logic [31:0]         r_data;
    logic                r_signed;
    logic                r_is_load;
    logic [31:0]         r_ld;
    logic [31:0]         r_dout;
    logic [MEM_AW-1:0]   r_mem_addr;
    logic [MEM_DW-1:0]   r_mem_wdata;

    logic                w_accept;
    logic [1:0]          w_in_off;
    logic [2:0]          w_in_size;
    logic [MEM_AW-1:0]   w_in_base;
    logic [1:0]          w_off;
    logic [2:0]          w_size;
    logic [MEM_AW-1:0]   w_base;
    logic [31:0]         w_data;
    logic [2:0]          w_nidx;
    logic                w_last;
    logic                w_more;
    logic [31:0]         w_ld_merge;
    logic [MEM_DW-1:0]   w_wr_data;
    logic [MEM_AW-1:0]   w_mem_addr;

    // CPU byte index carried by memory byte k of a beat; valid when in 0..sz-1
    function automatic logic covered(input int beat, input int off,
                                     input int sz, input int k);
        int j;
        j = beat * MEM_BYTES + k - off;
        return (j >= 0) && (j < sz);
    endfunction

    function automatic logic beat_full(input int beat, input int off,
                                       input int sz);
        logic f;
        f = 1'b1;
        for (int k = 0; k < MEM_BYTES; k++)
            if (!covered(beat, off, sz, k)) f = 1'b0;
        return f;
    endfunction

    function automatic logic [MEM_DW-1:0] wr_merge(
        input logic [MEM_DW-1:0] rd, input logic [31:0] d,
        input int beat, input int off, input int sz);
        logic [MEM_DW-1:0] w;
        int j;
        w = rd;
        for (int k = 0; k < MEM_BYTES; k++) begin
            j = beat * MEM_BYTES + k - off;
            if (j >= 0 && j < sz) w[8*k +: 8] = d[8*j +: 8];
        end
        return w;
    endfunction

    function automatic logic [31:0] ld_merge(
        input logic [31:0] acc, input logic [MEM_DW-1:0] rd,
        input int beat, input int off, input int sz);
        logic [31:0] a;
        int j;
        a = acc;
        for (int k = 0; k < MEM_BYTES; k++) begin
            j = beat * MEM_BYTES + k - off;
            if (j >= 0 && j < sz) a[8*j +: 8] = rd[8*k +: 8];
        end
        return a;
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] v,
                                           input logic [2:0] sz,
                                           input logic sg);
        logic [31:0] r;
        r = v;
        if (sz == 3'd1) r = {{24{sg & v[7]}}, v[7:0]};
        else if (sz == 3'd2) r = {{16{sg & v[15]}}, v[15:0]};
        return r;
    endfunction

    always_comb begin
        w_in_size = 3'd4;
        case (word_type)
            2'b00:   w_in_size = 3'd1;
            2'b01:   w_in_size = 3'd2;
            default: w_in_size = 3'd4;
        endcase
    end

    assign w_in_off  = address[1:0] & 2'(MEM_BYTES - 1);
    assign w_in_base = MEM_AW'(address >> OFF_W);
    assign w_accept  = (r_state == S_IDLE) && (load ^ store);

    // In IDLE the first beat is planned from live inputs, later from latches
    assign w_off  = (r_state == S_IDLE) ? w_in_off  : r_off;
    assign w_size = (r_state == S_IDLE) ? w_in_size : r_size;
    assign w_base = (r_state == S_IDLE) ? w_in_base : r_base;
    assign w_data = (r_state == S_IDLE) ? data_in   : r_data;

    assign w_last = (r_wait == 2'(READ_LAT - 1));
    assign w_more = ((r_beat + 3'd1) < r_nbeats);

    always_comb begin
        w_state_next = r_state;
        w_nidx       = r_beat + 3'd1;
        case (r_state)
            S_IDLE: begin
                w_nidx = 3'd0;
                if (w_accept)
                    w_state_next = (load || !beat_full(0, int'(w_off),
                                                       int'(w_size)))
                                   ? S_RD_ISSUE : S_WR;
            end
            S_RD_ISSUE: w_state_next = S_RD_WAIT;
            S_RD_WAIT: begin
                if (w_last) begin
                    if (r_is_load) begin
                        w_state_next = w_more ? S_RD_ISSUE : S_DONE;
                    end else begin
                        // RMW: write back the beat just read
                        w_nidx       = r_beat;
                        w_state_next = S_WR;
                    end
                end
            end
            S_WR: begin
                if (w_more)
                    w_state_next = beat_full(int'(w_nidx), int'(w_off),
                                             int'(w_size))
                                   ? S_WR : S_RD_ISSUE;
                else
                    w_state_next = S_DONE;
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_mem_addr = w_base + MEM_AW'(w_nidx);
    assign w_wr_data  = wr_merge(from_mem_data, w_data, int'(w_nidx),
                                 int'(w_off), int'(w_size));
    assign w_ld_merge = ld_merge(r_ld, from_mem_data, int'(r_beat),
                                 int'(r_off), int'(r_size));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_off       <= '0;
            r_size      <= '0;
            r_nbeats    <= '0;
            r_beat      <= '0;
            r_wait      <= '0;
            r_base      <= '0;
            r_data      <= '0;
            r_signed    <= 1'b0;
            r_is_load   <= 1'b0;
            r_ld        <= '0;
            r_dout      <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_off     <= w_in_off;
                r_size    <= w_in_size;
                r_nbeats  <= 3'((int'(w_in_off) + int'(w_in_size)
                                 + MEM_BYTES - 1) / MEM_BYTES);
                r_base    <= w_in_base;
                r_data    <= data_in;
                r_signed  <= is_signed;
                r_is_load <= load;
                r_ld      <= '0;
            end
            if (w_state_next == S_RD_ISSUE || w_state_next == S_WR) begin
                r_beat     <= w_nidx;
                r_mem_addr <= w_mem_addr;
            end
            if (w_state_next == S_WR)
                r_mem_wdata <= w_wr_data;
            if (r_state == S_RD_ISSUE)
                r_wait <= '0;
            else if (r_state == S_RD_WAIT)
                r_wait <= r_wait + 2'd1;
            if (r_state == S_RD_WAIT && w_last && r_is_load) begin
                r_ld <= w_ld_merge;
                if (!w_more)
                    r_dout <= extend(w_ld_merge, r_size, r_signed);
            end
        end
    end

    assign to_mem_read_enable  = (r_state == S_RD_ISSUE);
    assign to_mem_write_enable = (r_state == S_WR);
    assign to_mem_mem_enable   = to_mem_read_enable | to_mem_write_enable;
    assign to_mem_address      = r_mem_addr;
    assign to_mem_data         = r_mem_wdata;
    assign data_out            = r_dout;
    assign output_valid        = (r_state == S_DONE) && r_is_load;
    assign write_ready         = (r_state == S_DONE) && !r_is_load;
    assign busy                = (r_state != S_IDLE);

endmodule

// File: tb/tb_memory_interface_v4.sv
// Bench for memory_interface_v4 (MEM_BYTES=2, READ_LAT=1):
// directed ops, expectations queued at issue, checked by a pulse monitor.
module tb_memory_interface_v4;

    logic        clk = 1'b0;
    logic        reset;
    logic [12:0] address;
    logic [31:0] data_in;
    logic        load;
    logic        store;
    logic        is_signed;
    logic [1:0]  word_type;
    logic [15:0] from_mem_data;
    logic        to_mem_mem_enable;
    logic        to_mem_read_enable;
    logic        to_mem_write_enable;
    logic [11:0] to_mem_address;
    logic [15:0] to_mem_data;
    logic [31:0] data_out;
    logic        output_valid;
    logic        write_ready;
    logic        busy;

    always #5 clk = ~clk;

    memory_interface_v4 #(
        .ADDR_W(13), .MEM_BYTES(2), .READ_LAT(1)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .address             (address),
        .data_in             (data_in),
        .load                (load),
        .store               (store),
        .is_signed           (is_signed),
        .word_type           (word_type),
        .from_mem_data       (from_mem_data),
        .to_mem_mem_enable   (to_mem_mem_enable),
        .to_mem_read_enable  (to_mem_read_enable),
        .to_mem_write_enable (to_mem_write_enable),
        .to_mem_address      (to_mem_address),
        .to_mem_data         (to_mem_data),
        .data_out            (data_out),
        .output_valid        (output_valid),
        .write_ready         (write_ready),
        .busy                (busy)
    );

    logic [15:0] mem [0:4095];
    int cyc = 0;
    int n_cmp = 0;
    int n_fail = 0;

    // SRAM model: data valid one cycle after the read command edge
    always @(posedge clk) begin
        if (to_mem_read_enable) from_mem_data <= mem[to_mem_address];
        if (to_mem_write_enable) mem[to_mem_address] = to_mem_data;
    end

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        is_ld;
        logic [31:0] data;
        int          done_cyc;
        int          busy_n;
        int          nrd;
        int          nwr;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    int m_busy = 0;
    int m_rd = 0;
    int m_wr = 0;

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            m_busy = 0;
            m_rd   = 0;
            m_wr   = 0;
        end else begin
            if (busy) m_busy++;
            if (to_mem_read_enable) m_rd++;
            if (to_mem_write_enable) m_wr++;
            chk("rd_wr_overlap",
                {31'b0, to_mem_read_enable & to_mem_write_enable}, 32'd0);
            chk("mem_enable", {31'b0, to_mem_mem_enable},
                {31'b0, to_mem_read_enable | to_mem_write_enable});
            if (output_valid || write_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pulse",
                        {30'b0, output_valid, write_ready}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("pulse_kind", {30'b0, output_valid, write_ready},
                        e.is_ld ? 32'd2 : 32'd1);
                    if (e.is_ld) chk("data_out", data_out, e.data);
                    chk("done_cycle", cyc, e.done_cyc);
                    chk("busy_cycles", m_busy, e.busy_n);
                    chk("read_beats", m_rd, e.nrd);
                    chk("write_beats", m_wr, e.nwr);
                end
                m_busy = 0;
                m_rd   = 0;
                m_wr   = 0;
            end
        end
    end

    task automatic issue(input logic ld, input logic st,
                         input logic [12:0] a, input logic [31:0] d,
                         input logic sg, input logic [1:0] wt,
                         input logic [31:0] exp_d, input int b,
                         input int nrd, input int nwr);
        exp_t e;
        @(negedge clk);
        load      = ld;
        store     = st;
        address   = a;
        data_in   = d;
        is_signed = sg;
        word_type = wt;
        @(posedge clk);
        #1;
        load      = 1'b0;
        store     = 1'b0;
        address   = 13'h0AA;
        data_in   = 32'hC3C3C3C3;
        is_signed = ~sg;
        word_type = 2'b00;
        e.is_ld    = ld;
        e.data     = exp_d;
        e.done_cyc = cyc + b;
        e.busy_n   = b + 1;
        e.nrd      = nrd;
        e.nwr      = nwr;
        sb.push_back(e);
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(nm, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        reset     = 1'b0;
        address   = '0;
        data_in   = '0;
        load      = 1'b0;
        store     = 1'b0;
        is_signed = 1'b0;
        word_type = 2'b00;
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;

        repeat (3) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_pulses", {30'b0, output_valid, write_ready}, 32'd0);
        chk("rst_enables", {29'b0, to_mem_mem_enable, to_mem_read_enable,
                            to_mem_write_enable}, 32'd0);
        chk("rst_data_out", data_out, 32'd0);
        chk("rst_mem_addr", {20'b0, to_mem_address}, 32'd0);
        chk("rst_mem_data", {16'b0, to_mem_data}, 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        mem[8] = 16'h1234; mem[9] = 16'hABCD;
        issue(1, 0, 13'h010, 0, 0, 2'b10, 32'hABCD1234, 4, 2, 0);
        wait_idle("idle_wload");

        mem[9] = 16'h80FF;
        issue(1, 0, 13'h013, 0, 1, 2'b00, 32'hFFFFFF80, 2, 1, 0);
        wait_idle("idle_bload_s");
        issue(1, 0, 13'h013, 0, 0, 2'b00, 32'h00000080, 2, 1, 0);
        wait_idle("idle_bload_u");

        mem[8] = 16'h2211; mem[9] = 16'h4433; mem[10] = 16'h6655;
        issue(1, 0, 13'h011, 0, 0, 2'b10, 32'h55443322, 6, 3, 0);
        wait_idle("idle_mis_wload");

        mem[8] = 16'h1234;
        issue(0, 1, 13'h011, 32'h0000005A, 0, 2'b00, 0, 3, 1, 1);
        wait_idle("idle_bstore");
        chk("bstore_mem8", {16'b0, mem[8]}, 32'h00005A34);
        chk("data_out_hold", data_out, 32'h55443322);

        mem[16] = 16'h0; mem[17] = 16'h0;
        issue(0, 1, 13'h020, 32'hDEADBEEF, 0, 2'b10, 0, 2, 0, 2);
        wait_idle("idle_wstore");
        chk("wstore_mem16", {16'b0, mem[16]}, 32'h0000BEEF);
        chk("wstore_mem17", {16'b0, mem[17]}, 32'h0000DEAD);

        mem[4095] = 16'h12AB; mem[0] = 16'h34CD;
        issue(1, 0, 13'h1FFF, 0, 0, 2'b01, 32'h0000CD12, 4, 2, 0);
        wait_idle("idle_wrap_u");
        issue(1, 0, 13'h1FFF, 0, 1, 2'b01, 32'hFFFFCD12, 4, 2, 0);
        wait_idle("idle_wrap_s");

        mem[10] = 16'h1111; mem[11] = 16'h2222;
        issue(0, 1, 13'h015, 32'h1234BEEF, 0, 2'b01, 0, 6, 2, 2);
        wait_idle("idle_hstore");
        chk("hstore_mem10", {16'b0, mem[10]}, 32'h0000EF11);
        chk("hstore_mem11", {16'b0, mem[11]}, 32'h000022BE);

        mem[24] = 16'hAAAA; mem[25] = 16'hCCCC; mem[26] = 16'hBBBB;
        issue(0, 1, 13'h031, 32'h44332211, 0, 2'b11, 0, 7, 2, 3);
        wait_idle("idle_mis_wstore");
        chk("mstore_mem24", {16'b0, mem[24]}, 32'h000011AA);
        chk("mstore_mem25", {16'b0, mem[25]}, 32'h00003322);
        chk("mstore_mem26", {16'b0, mem[26]}, 32'h0000BB44);

        @(negedge clk);
        load = 1'b1; store = 1'b1; address = 13'h010; word_type = 2'b10;
        @(negedge clk);
        chk("both_busy", {31'b0, busy}, 32'd0);
        load = 1'b0; store = 1'b0;
        @(negedge clk);
        chk("both_busy2", {31'b0, busy}, 32'd0);
        chk("both_noread", {31'b0, to_mem_read_enable}, 32'd0);

        mem[8] = 16'h5678; mem[9] = 16'h9ABC;
        mem[32] = 16'h7777; mem[33] = 16'h8888;
        issue(1, 0, 13'h010, 0, 0, 2'b10, 32'h9ABC5678, 4, 2, 0);
        @(negedge clk);
        store = 1'b1; address = 13'h040; data_in = 32'hFFFFFFFF;
        word_type = 2'b10;
        @(negedge clk);
        store = 1'b0;
        wait_idle("idle_busy_req");
        chk("busy_req_mem32", {16'b0, mem[32]}, 32'h00007777);
        chk("busy_req_mem33", {16'b0, mem[33]}, 32'h00008888);

        mem[24] = 16'hAAAA; mem[25] = 16'hCCCC; mem[26] = 16'hBBBB;
        issue(0, 1, 13'h031, 32'h88776655, 0, 2'b10, 0, 7, 2, 3);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        sb.delete();
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_enables", {29'b0, to_mem_mem_enable, to_mem_read_enable,
                                to_mem_write_enable}, 32'd0);
        chk("mid_rst_data_out", data_out, 32'd0);
        chk("mid_rst_mem_addr", {20'b0, to_mem_address}, 32'd0);
        chk("mid_rst_mem_data", {16'b0, to_mem_data}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        chk("abort_mem24", {16'b0, mem[24]}, 32'h000055AA);
        chk("abort_mem25", {16'b0, mem[25]}, 32'h0000CCCC);
        chk("abort_mem26", {16'b0, mem[26]}, 32'h0000BBBB);
        chk("abort_idle", {31'b0, busy}, 32'd0);

        chk("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
